// File: rtl/boid_frame_scheduler_if.sv
// Shared boid selector bus plus display RAM write port between the frame
// scheduler (master) and the BPU array / display RAM (slave).
interface boid_frame_scheduler_if #(
  parameter int SEL_W  = 2,
  parameter int ADDR_W = 20
);
  logic [SEL_W-1:0]  boid_sel;
  logic [ADDR_W-1:0] boid_addr;
  logic              ram_swap;
  logic              disp_we;
  logic [ADDR_W-1:0] disp_addr;

  modport master (
    output boid_sel, ram_swap, disp_we, disp_addr,
    input  boid_addr
  );

  modport slave (
    input  boid_sel, ram_swap, disp_we, disp_addr,
    output boid_addr
  );
endinterface

// File: rtl/boid_frame_scheduler.sv
// Per-frame sequencer: swaps/clears the display RAM on screen_end, then walks
// every active BPU and writes one pixel per on-screen boid.
module boid_frame_scheduler #(
  parameter int MAX_BOIDS     = 4,
  parameter int SEL_W         = $clog2(MAX_BOIDS),
  parameter int PIXEL_COUNT   = 307200,
  parameter int ADDR_W        = $clog2(PIXEL_COUNT) + 1,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  CPU_RESETN,
  input  logic                  screen_end,
  input  logic [SEL_W:0]        active_boids,
  input  logic                  overrun_clr,
  boid_frame_scheduler_if.master bus,
  output logic                  busy,
  output logic [15:0]           frame_cnt,
  output logic                  overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWAP,
    S_SETTLE,
    S_WRITE,
    S_DONE
  } state_t;

  localparam int                CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SEL_W:0]    MAX_N       = (SEL_W + 1)'(MAX_BOIDS);
  localparam logic [ADDR_W-1:0] PIX_LIMIT   = ADDR_W'(PIXEL_COUNT);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t            state_q, state_d;
  logic [SEL_W:0]    n_q, n_d;
  logic [CNT_W-1:0]  settle_q, settle_d;
  logic              pending_q, pending_d;
  logic [SEL_W-1:0]  sel_d;
  logic [ADDR_W-1:0] addr_d;
  logic              we_d;
  logic [15:0]       frame_d;
  logic              overrun_d;
  logic [SEL_W:0]    n_clamped;
  logic              last_boid;

  assign n_clamped = (active_boids > MAX_N) ? MAX_N : active_boids;
  assign last_boid = (({1'b0, bus.boid_sel} + (SEL_W + 1)'(1)) == n_q);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    settle_d  = settle_q;
    pending_d = pending_q;
    sel_d     = bus.boid_sel;
    addr_d    = bus.disp_addr;
    we_d      = 1'b0;
    frame_d   = frame_cnt;
    overrun_d = overrun;

    // A frame request arriving mid-scan is remembered once and flagged.
    if (screen_end && (state_q inside {S_SWAP, S_SETTLE, S_WRITE})) pending_d = 1'b1;

    case (state_q)
      S_IDLE: if (screen_end) state_d = S_SWAP;
      S_SWAP: begin
        n_d      = n_clamped;
        sel_d    = '0;
        settle_d = '0;
        state_d  = (n_clamped == '0) ? S_DONE : S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_WRITE;
          addr_d  = bus.boid_addr;
          we_d    = (bus.boid_addr < PIX_LIMIT);
        end else begin
          settle_d = settle_q + CNT_W'(1);
        end
      end
      S_WRITE: begin
        settle_d = '0;
        if (last_boid) begin
          sel_d   = '0;
          state_d = S_DONE;
        end else begin
          sel_d   = bus.boid_sel + SEL_W'(1);
          state_d = S_SETTLE;
        end
      end
      S_DONE: begin
        // A request seen during DONE itself goes straight to SWAP as well.
        if (pending_q || screen_end) begin
          pending_d = 1'b0;
          state_d   = S_SWAP;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE) frame_d = frame_cnt + 16'd1;

    if (screen_end && (state_q != S_IDLE)) overrun_d = 1'b1;
    else if (overrun_clr)                  overrun_d = 1'b0;
  end

  // NOTE: state and outputs use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clock or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q       <= S_IDLE;
      n_q           <= '0;
      settle_q      <= '0;
      pending_q     <= 1'b0;
      bus.boid_sel  <= '0;
      bus.ram_swap  <= 1'b0;
      bus.disp_we   <= 1'b0;
      bus.disp_addr <= '0;
      busy          <= 1'b0;
      frame_cnt     <= '0;
      overrun       <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      settle_q      <= settle_d;
      pending_q     <= pending_d;
      bus.boid_sel  <= sel_d;
      bus.ram_swap  <= (state_d == S_SWAP);
      bus.disp_we   <= we_d;
      bus.disp_addr <= addr_d;
      busy          <= (state_d inside {S_SWAP, S_SETTLE, S_WRITE});
      frame_cnt     <= frame_d;
      overrun       <= overrun_d;
    end
  end

endmodule

// File: tb/tb_boid_frame_scheduler.sv
// Scoreboard bench for boid_frame_scheduler: expected pixel writes are queued
// as each frame is launched and matched by a monitor as disp_we pulses appear.
module tb_boid_frame_scheduler;

  localparam int MAX_BOIDS = 4;
  localparam int SEL_W     = 2;
  localparam int ADDR_W    = 20;

  logic             clock = 1'b0;
  logic             CPU_RESETN = 1'b1;
  logic             screen_end = 1'b0;
  logic             overrun_clr = 1'b0;
  logic [SEL_W:0]   active_boids = '0;
  logic             busy;
  logic [15:0]      frame_cnt;
  logic             overrun;

  logic [ADDR_W-1:0] addr_table [MAX_BOIDS];
  logic [ADDR_W-1:0] exp_q [$];
  int                wr_cyc [$];
  int                checks = 0;
  int                errors = 0;
  int                nwr = 0;
  int                cyc = 0;
  logic [15:0]       exp_frames = '0;

  boid_frame_scheduler_if #(.SEL_W(SEL_W), .ADDR_W(ADDR_W)) bif ();

  assign bif.boid_addr = addr_table[bif.boid_sel];

  boid_frame_scheduler #(
    .MAX_BOIDS(MAX_BOIDS), .SEL_W(SEL_W), .PIXEL_COUNT(307200),
    .ADDR_W(ADDR_W), .SETTLE_CYCLES(1)
  ) dut (
    .clock(clock),
    .CPU_RESETN(CPU_RESETN),
    .screen_end(screen_end),
    .active_boids(active_boids),
    .overrun_clr(overrun_clr),
    .bus(bif.master),
    .busy(busy),
    .frame_cnt(frame_cnt),
    .overrun(overrun)
  );

  always #10 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Write monitor: pops the scoreboard on every disp_we pulse.
  always @(negedge clock) begin
    if (CPU_RESETN && bif.disp_we) begin
      logic [ADDR_W-1:0] exp_addr;
      nwr++;
      wr_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got addr %0d, none expected", bif.disp_addr);
      end else begin
        exp_addr = exp_q.pop_front();
        if (bif.disp_addr !== exp_addr) begin
          errors++;
          $display("FAIL write_addr: got %0d, expected %0d", bif.disp_addr, exp_addr);
        end
      end
      checks++;
      if (bif.ram_swap !== 1'b0) begin
        errors++;
        $display("FAIL swap_with_write: ram_swap %0b during disp_we, expected 0", bif.ram_swap);
      end
    end
  end

  task automatic set_table(input logic [ADDR_W-1:0] a0, a1, a2, a3);
    addr_table[0] = a0;
    addr_table[1] = a1;
    addr_table[2] = a2;
    addr_table[3] = a3;
  endtask

  task automatic run_frame(output int swap_c, output int swap_n, output int busy_c, output int done_c);
    logic [15:0] f0;
    f0     = frame_cnt;
    swap_c = -1;
    swap_n = 0;
    busy_c = 0;
    done_c = -1;
    @(negedge clock);
    screen_end = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      screen_end = 1'b0;
      if (bif.ram_swap) begin
        swap_n++;
        if (swap_c < 0) swap_c = cyc;
      end
      if (busy) busy_c++;
      if (frame_cnt !== f0) begin
        done_c = cyc;
        break;
      end
    end
    if (done_c < 0) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: frame_cnt stuck at %0d after 64 cycles", frame_cnt);
    end
  endtask

  task automatic test_reset();
    CPU_RESETN = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (bif.ram_swap !== 1'b0) begin errors++; $display("FAIL reset_ram_swap: got %0b expected 0", bif.ram_swap); end
    checks++;
    if (bif.disp_we !== 1'b0) begin errors++; $display("FAIL reset_disp_we: got %0b expected 0", bif.disp_we); end
    checks++;
    if (bif.disp_addr !== '0) begin errors++; $display("FAIL reset_disp_addr: got %0d expected 0", bif.disp_addr); end
    checks++;
    if (bif.boid_sel !== '0) begin errors++; $display("FAIL reset_boid_sel: got %0d expected 0", bif.boid_sel); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++;
    if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
    CPU_RESETN = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_basic_frame();
    int sc, sn, bc, dc, w0;
    set_table(20'd6410, 20'd7410, 20'd8410, 20'd9410);
    active_boids = 3'd4;
    for (int k = 0; k < 4; k++) exp_q.push_back(addr_table[k]);
    wr_cyc.delete();
    w0 = nwr;
    run_frame(sc, sn, bc, dc);
    exp_frames++;
    checks++;
    if (sn != 1) begin errors++; $display("FAIL basic_swap_len: got %0d cycles expected 1", sn); end
    checks++;
    if (nwr - w0 != 4) begin errors++; $display("FAIL basic_write_count: got %0d expected 4", nwr - w0); end
    for (int k = 0; k < 4; k++) begin
      if (k < wr_cyc.size()) begin
        checks++;
        if (wr_cyc[k] != sc + 2 + 2 * k) begin
          errors++;
          $display("FAIL basic_write_time%0d: got cycle %0d expected %0d", k, wr_cyc[k], sc + 2 + 2 * k);
        end
      end
    end
    checks++;
    if (dc != sc + 9) begin errors++; $display("FAIL basic_done_time: got %0d expected %0d", dc, sc + 9); end
    checks++;
    if (bc != 9) begin errors++; $display("FAIL basic_busy_len: got %0d expected 9", bc); end
    checks++;
    if (frame_cnt !== exp_frames || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_state: frame_cnt %0d busy %0b, expected %0d and 0", frame_cnt, busy, exp_frames);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL basic_missing_writes: %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_zero_boids();
    int sc, sn, bc, dc, w0;
    active_boids = 3'd0;
    w0 = nwr;
    run_frame(sc, sn, bc, dc);
    exp_frames++;
    checks++;
    if (sn != 1) begin errors++; $display("FAIL zero_swap_len: got %0d expected 1", sn); end
    checks++;
    if (nwr != w0) begin errors++; $display("FAIL zero_writes: got %0d expected 0", nwr - w0); end
    checks++;
    if (dc != sc + 1) begin errors++; $display("FAIL zero_done_time: got %0d expected %0d", dc, sc + 1); end
    checks++;
    if (bc != 1) begin errors++; $display("FAIL zero_busy_len: got %0d expected 1", bc); end
    checks++;
    if (frame_cnt !== exp_frames) begin errors++; $display("FAIL zero_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_offscreen();
    int sc, sn, bc, dc, w0;
    set_table(20'd6410, 20'd7410, 20'd307200, 20'd307199);
    active_boids = 3'd4;
    exp_q.push_back(20'd6410);
    exp_q.push_back(20'd7410);
    exp_q.push_back(20'd307199);
    wr_cyc.delete();
    w0 = nwr;
    run_frame(sc, sn, bc, dc);
    exp_frames++;
    checks++;
    if (nwr - w0 != 3) begin errors++; $display("FAIL offscreen_write_count: got %0d expected 3", nwr - w0); end
    if (wr_cyc.size() == 3) begin
      checks++;
      if (wr_cyc[2] != sc + 8) begin errors++; $display("FAIL offscreen_boid3_time: got %0d expected %0d", wr_cyc[2], sc + 8); end
    end
    checks++;
    if (dc != sc + 9) begin errors++; $display("FAIL offscreen_done_time: got %0d expected %0d", dc, sc + 9); end
    checks++;
    if (frame_cnt !== exp_frames) begin errors++; $display("FAIL offscreen_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_clamp();
    int sc, sn, bc, dc, w0;
    set_table(20'd100, 20'd200, 20'd300, 20'd400);
    active_boids = 3'd7;
    for (int k = 0; k < 4; k++) exp_q.push_back(addr_table[k]);
    w0 = nwr;
    run_frame(sc, sn, bc, dc);
    exp_frames++;
    checks++;
    if (nwr - w0 != 4) begin errors++; $display("FAIL clamp_write_count: got %0d expected 4", nwr - w0); end
    checks++;
    if (bc != 9) begin errors++; $display("FAIL clamp_busy_len: got %0d expected 9", bc); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL clamp_missing_writes: %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit found;
    set_table(20'd6410, 20'd7410, 20'd8410, 20'd9410);
    active_boids = 3'd4;
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 4; k++) exp_q.push_back(addr_table[k]);
    @(negedge clock);
    screen_end = 1'b1;
    @(negedge clock);
    screen_end = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bif.boid_sel == 2'd1 && !bif.disp_we) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL b2b_settle1_timeout: boid 1 settle not seen"); end
    // Second request collides with a clear request: the set must win.
    screen_end  = 1'b1;
    overrun_clr = 1'b1;
    @(negedge clock);
    screen_end  = 1'b0;
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun_set: got %0b expected 1", overrun); end
    exp_frames++;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (frame_cnt === exp_frames) begin found = 1'b1; break; end
      @(negedge clock);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL b2b_first_done_timeout: frame_cnt %0d expected %0d", frame_cnt, exp_frames); end
    @(negedge clock);
    checks++;
    if (bif.ram_swap !== 1'b1) begin errors++; $display("FAIL b2b_second_swap: ram_swap %0b after DONE, expected 1", bif.ram_swap); end
    exp_frames++;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (frame_cnt === exp_frames) begin found = 1'b1; break; end
      @(negedge clock);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL b2b_second_done_timeout: frame_cnt %0d expected %0d", frame_cnt, exp_frames); end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun_sticky: got %0b expected 1", overrun); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing_writes: %0d left, expected 0", exp_q.size()); end
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy %0b expected 0", busy); end
    overrun_clr = 1'b1;
    @(negedge clock);
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun_clr: got %0b expected 0", overrun); end
  endtask

  task automatic test_reset_mid_scan();
    bit found;
    int w0;
    set_table(20'd6410, 20'd7410, 20'd8410, 20'd9410);
    active_boids = 3'd4;
    exp_q.push_back(20'd6410);
    exp_q.push_back(20'd7410);
    @(negedge clock);
    screen_end = 1'b1;
    @(negedge clock);
    screen_end = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bif.boid_sel == 2'd1 && bif.disp_we) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rstmid_write1_timeout: boid 1 write not seen"); end
    #1;
    CPU_RESETN = 1'b0;
    #1;
    checks++;
    if ({bif.ram_swap, bif.disp_we, bif.disp_addr, bif.boid_sel, busy, frame_cnt, overrun} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: swap %0b we %0b addr %0d sel %0d busy %0b frames %0d ovr %0b, expected all 0",
               bif.ram_swap, bif.disp_we, bif.disp_addr, bif.boid_sel, busy, frame_cnt, overrun);
    end
    @(negedge clock);
    CPU_RESETN = 1'b1;
    exp_frames = '0;
    w0 = nwr;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (busy || bif.ram_swap) found = 1'b1;
    end
    checks++;
    if (found || nwr != w0) begin errors++; $display("FAIL rstmid_stays_idle: activity %0b writes %0d, expected none", found, nwr - w0); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_scoreboard: %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_frame_wrap();
    int sc, sn, bc, dc;
    active_boids = 3'd0;
    @(negedge clock);
    force dut.frame_cnt = 16'hFFFE;
    #1;
    release dut.frame_cnt;
    run_frame(sc, sn, bc, dc);
    checks++;
    if (frame_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got %0d expected 65535", frame_cnt); end
    run_frame(sc, sn, bc, dc);
    checks++;
    if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", frame_cnt); end
  endtask

  initial begin
    set_table(20'd6410, 20'd7410, 20'd8410, 20'd9410);
    test_reset();
    test_basic_frame();
    test_zero_boids();
    test_offscreen();
    test_clamp();
    test_back_to_back();
    test_reset_mid_scan();
    test_frame_wrap();
    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
